pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl_pkg.sv | 22 ++
 rtl/pipe_hazard_ctrl_if.sv | 41 ++++
 rtl/pipe_hazard_ctrl_fwd_unit.sv | 23 ++
 rtl/pipe_hazard_ctrl.sv | 133 +++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/pipe_hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forwarding selects,
// controller FSM states and a register-match helper.
package pipe_pkg;

    typedef enum logic [1:0] {
        FWD_RF = 2'b00,
        FWD_W  = 2'b01,
        FWD_M  = 2'b10
    } fwd_sel_e;

    typedef enum logic [1:0] {
        ST_RUN      = 2'b00,
        ST_MEM_WAIT = 2'b01,
        ST_ERR      = 2'b10
    } ctrl_state_e;

    // x0 is hard-wired zero, so it never creates a dependency.
    function automatic logic reg_match(input logic [4:0] rd, input logic [4:0] rs);
        return (rd != 5'd0) && (rd == rs);
    endfunction

endpackage

// File: rtl/pipe_hazard_ctrl_if.sv
// Bundle between the pipeline datapath (master) and the hazard controller (slave).
interface pipe_hazard_ctrl_if;
    logic [4:0] rs1_D;
    logic [4:0] rs2_D;
    logic [4:0] rs1_E;
    logic [4:0] rs2_E;
    logic [4:0] rd_E;
    logic [4:0] rd_M;
    logic [4:0] rd_W;
    logic       mem_rd_E;
    logic       reg_wr_M;
    logic       reg_wr_W;
    logic       pc_src_E;
    logic       dmem_req_M;
    logic       dmem_ack;
    logic       stall_F;
    logic       stall_D;
    logic       stall_E;
    logic       stall_M;
    logic       flush_D;
    logic       flush_E;
    logic       flush_W;
    logic [1:0] fwd_a_E;
    logic [1:0] fwd_b_E;
    logic       mem_timeout;
    logic [1:0] ctrl_state;

    modport master (
        output rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
        output mem_rd_E, reg_wr_M, reg_wr_W, pc_src_E, dmem_req_M, dmem_ack,
        input  stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
        input  fwd_a_E, fwd_b_E, mem_timeout, ctrl_state
    );

    modport slave (
        input  rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W,
        input  mem_rd_E, reg_wr_M, reg_wr_W, pc_src_E, dmem_req_M, dmem_ack,
        output stall_F, stall_D, stall_E, stall_M, flush_D, flush_E, flush_W,
        output fwd_a_E, fwd_b_E, mem_timeout, ctrl_state
    );
endinterface

// File: rtl/pipe_hazard_ctrl_fwd_unit.sv
// Combinational operand-forwarding select for one execute-stage source register.
module pipe_fwd_unit
    import pipe_pkg::*;
(
    input  logic       reg_wr_M,
    input  logic [4:0] rd_M,
    input  logic       reg_wr_W,
    input  logic [4:0] rd_W,
    input  logic [4:0] rs_E,
    output fwd_sel_e   fwd_sel
);

    // M holds the younger result, so it wins over W.
    always_comb begin
        fwd_sel = FWD_RF;
        if (reg_wr_M && reg_match(rd_M, rs_E)) begin
            fwd_sel = FWD_M;
        end else if (reg_wr_W && reg_match(rd_W, rs_E)) begin
            fwd_sel = FWD_W;
        end
    end

endmodule

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: memory-wait FSM with timeout, load-use and
// redirect handling, plus operand forwarding for the execute stage.
module pipe_hazard_ctrl
    import pipe_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
) (
    input  logic               clk,
    input  logic               rst_n,
    pipe_hazard_ctrl_if.slave  hz
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYC);

    ctrl_state_e      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             mem_timeout_q, mem_timeout_d;
    logic             lu_hold_q, lu_hold_d;

    logic mem_pend;
    logic lu_raw;
    logic stall_f, stall_d, stall_e, stall_m;
    logic flush_d, flush_e, flush_w;

    fwd_sel_e fwd_a, fwd_b;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= ST_RUN;
            cnt_q         <= '0;
            mem_timeout_q <= 1'b0;
            lu_hold_q     <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            mem_timeout_q <= mem_timeout_d;
            lu_hold_q     <= lu_hold_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        mem_timeout_d = mem_timeout_q;
        lu_hold_d     = 1'b0;
        stall_f       = 1'b0;
        stall_d       = 1'b0;
        stall_e       = 1'b0;
        stall_m       = 1'b0;
        flush_d       = 1'b0;
        flush_e       = 1'b0;
        flush_w       = 1'b0;

        mem_pend = hz.dmem_req_M && !hz.dmem_ack;
        lu_raw   = hz.mem_rd_E &&
                   (reg_match(hz.rd_E, hz.rs1_D) || reg_match(hz.rd_E, hz.rs2_D));

        unique case (state_q)
            ST_RUN: begin
                if (mem_pend) begin
                    state_d = ST_MEM_WAIT;
                    cnt_d   = '0;
                end
            end
            ST_MEM_WAIT: begin
                if (hz.dmem_ack) begin
                    state_d = ST_RUN;
                end else if (cnt_q == CNT_LIMIT) begin
                    state_d       = ST_ERR;
                    mem_timeout_d = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            ST_ERR: begin
                state_d = ST_ERR;
            end
            default: begin
                state_d = ST_RUN;
            end
        endcase

        // lu_hold_q masks the cycle after a load-use bubble so a held
        // instruction pair only stalls once.
        if (state_q == ST_ERR || mem_pend) begin
            stall_f = 1'b1;
            stall_d = 1'b1;
            stall_e = 1'b1;
            stall_m = 1'b1;
            flush_w = 1'b1;
        end else if (state_q == ST_RUN && hz.pc_src_E) begin
            flush_d = 1'b1;
            flush_e = 1'b1;
        end else if (state_q == ST_RUN && lu_raw && !lu_hold_q) begin
            stall_f   = 1'b1;
            stall_d   = 1'b1;
            flush_e   = 1'b1;
            lu_hold_d = 1'b1;
        end
    end

    pipe_fwd_unit u_fwd_a (
        .reg_wr_M (hz.reg_wr_M),
        .rd_M     (hz.rd_M),
        .reg_wr_W (hz.reg_wr_W),
        .rd_W     (hz.rd_W),
        .rs_E     (hz.rs1_E),
        .fwd_sel  (fwd_a)
    );

    pipe_fwd_unit u_fwd_b (
        .reg_wr_M (hz.reg_wr_M),
        .rd_M     (hz.rd_M),
        .reg_wr_W (hz.reg_wr_W),
        .rd_W     (hz.rd_W),
        .rs_E     (hz.rs2_E),
        .fwd_sel  (fwd_b)
    );

    assign hz.stall_F     = stall_f;
    assign hz.stall_D     = stall_d;
    assign hz.stall_E     = stall_e;
    assign hz.stall_M     = stall_m;
    assign hz.flush_D     = flush_d;
    assign hz.flush_E     = flush_e;
    assign hz.flush_W     = flush_w;
    assign hz.fwd_a_E     = fwd_a;
    assign hz.fwd_b_E     = fwd_b;
    assign hz.mem_timeout = mem_timeout_q;
    assign hz.ctrl_state  = state_q;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Directed bench for pipe_hazard_ctrl: combinational vector table plus
// hand-written memory-wait, timeout, load-use and async-reset sequences.
module tb_pipe_hazard_ctrl;

    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    pipe_hazard_ctrl_if hif();

    pipe_hazard_ctrl #(.TIMEOUT_CYC(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .hz    (hif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string      name;
        logic [4:0] rs1_D, rs2_D, rs1_E, rs2_E, rd_E, rd_M, rd_W;
        logic       mem_rd_E, reg_wr_M, reg_wr_W, pc_src_E, dmem_req_M, dmem_ack;
        logic [3:0] exp_stall;  // {F,D,E,M}
        logic [2:0] exp_flush;  // {D,E,W}
        logic [1:0] exp_fa, exp_fb;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(
        input string nm,
        input logic [4:0] rs1d, rs2d, rs1e, rs2e, rde, rdm, rdw,
        input logic mrd, wrm, wrw, pcs, req, ack,
        input logic [3:0] st, input logic [2:0] fl,
        input logic [1:0] fa, fb);
        vec_t v;
        v.name = nm;
        v.rs1_D = rs1d; v.rs2_D = rs2d; v.rs1_E = rs1e; v.rs2_E = rs2e;
        v.rd_E = rde; v.rd_M = rdm; v.rd_W = rdw;
        v.mem_rd_E = mrd; v.reg_wr_M = wrm; v.reg_wr_W = wrw;
        v.pc_src_E = pcs; v.dmem_req_M = req; v.dmem_ack = ack;
        v.exp_stall = st; v.exp_flush = fl; v.exp_fa = fa; v.exp_fb = fb;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic drive_idle();
        hif.rs1_D = '0; hif.rs2_D = '0; hif.rs1_E = '0; hif.rs2_E = '0;
        hif.rd_E = '0; hif.rd_M = '0; hif.rd_W = '0;
        hif.mem_rd_E = 1'b0; hif.reg_wr_M = 1'b0; hif.reg_wr_W = 1'b0;
        hif.pc_src_E = 1'b0; hif.dmem_req_M = 1'b0; hif.dmem_ack = 1'b1;
    endtask

    task automatic drive_vec(input vec_t v);
        hif.rs1_D = v.rs1_D; hif.rs2_D = v.rs2_D; hif.rs1_E = v.rs1_E; hif.rs2_E = v.rs2_E;
        hif.rd_E = v.rd_E; hif.rd_M = v.rd_M; hif.rd_W = v.rd_W;
        hif.mem_rd_E = v.mem_rd_E; hif.reg_wr_M = v.reg_wr_M; hif.reg_wr_W = v.reg_wr_W;
        hif.pc_src_E = v.pc_src_E; hif.dmem_req_M = v.dmem_req_M; hif.dmem_ack = v.dmem_ack;
    endtask

    function automatic logic [7:0] stalls();
        return {4'b0, hif.stall_F, hif.stall_D, hif.stall_E, hif.stall_M};
    endfunction

    function automatic logic [7:0] flushes();
        return {5'b0, hif.flush_D, hif.flush_E, hif.flush_W};
    endfunction

    initial begin
        int edges;
        total = 0;
        bad   = 0;

        //            name          rs1D rs2D rs1E rs2E rdE rdM rdW mrd wrM wrW pcs req ack stall    flush   fa     fb
        vecs.push_back(mk("idle",      0, 0, 0, 0, 0, 0, 0, 0,0,0,0,0,0, 4'b0000, 3'b000, 2'b00, 2'b00));
        vecs.push_back(mk("lu_rs1",    5, 1, 0, 0, 5, 0, 0, 1,0,0,0,0,0, 4'b1100, 3'b010, 2'b00, 2'b00));
        vecs.push_back(mk("lu_rs2",    2, 9, 0, 0, 9, 0, 0, 1,0,0,0,0,0, 4'b1100, 3'b010, 2'b00, 2'b00));
        vecs.push_back(mk("lu_x0",     0, 0, 0, 0, 0, 0, 0, 1,0,0,0,0,0, 4'b0000, 3'b000, 2'b00, 2'b00));
        vecs.push_back(mk("no_load",   5, 0, 0, 0, 5, 0, 0, 0,0,0,0,0,0, 4'b0000, 3'b000, 2'b00, 2'b00));
        vecs.push_back(mk("redirect",  0, 0, 0, 0, 0, 0, 0, 0,0,0,1,0,0, 4'b0000, 3'b110, 2'b00, 2'b00));
        vecs.push_back(mk("redir_lu",  5, 0, 0, 0, 5, 0, 0, 1,0,0,1,0,0, 4'b0000, 3'b110, 2'b00, 2'b00));
        vecs.push_back(mk("mem_stall", 0, 0, 0, 0, 0, 0, 0, 0,0,0,0,1,0, 4'b1111, 3'b001, 2'b00, 2'b00));
        vecs.push_back(mk("mem_prio",  5, 0, 0, 0, 5, 0, 0, 1,0,0,1,1,0, 4'b1111, 3'b001, 2'b00, 2'b00));
        vecs.push_back(mk("req_ack",   0, 0, 0, 0, 0, 0, 0, 0,0,0,0,1,1, 4'b0000, 3'b000, 2'b00, 2'b00));
        vecs.push_back(mk("fwd_m",     0, 0, 7, 0, 0, 7, 7, 0,1,1,0,0,0, 4'b0000, 3'b000, 2'b10, 2'b00));
        vecs.push_back(mk("fwd_w",     0, 0, 7, 0, 0, 0, 7, 0,1,1,0,0,0, 4'b0000, 3'b000, 2'b01, 2'b00));
        vecs.push_back(mk("fwd_b_w",   0, 0, 0, 3, 0, 3, 3, 0,0,1,0,0,0, 4'b0000, 3'b000, 2'b00, 2'b01));
        vecs.push_back(mk("fwd_x0",    0, 0, 0, 0, 0, 0, 0, 0,1,1,0,0,0, 4'b0000, 3'b000, 2'b00, 2'b00));
        vecs.push_back(mk("fwd_nowr",  0, 0, 6, 6, 0, 6, 6, 0,0,0,0,0,0, 4'b0000, 3'b000, 2'b00, 2'b00));
        vecs.push_back(mk("fwd_stall", 0, 0, 4, 8, 0, 4, 8, 0,1,1,0,1,0, 4'b1111, 3'b001, 2'b10, 2'b01));

        // Reset state
        rst_n = 1'b0;
        drive_idle();
        #12;
        chk("rst_state", {6'b0, hif.ctrl_state}, 8'h00);
        chk("rst_timeout", {7'b0, hif.mem_timeout}, 8'h00);
        chk("rst_stall", stalls(), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Vector table: each vector is followed by two idle edges so the
        // load-use mask and any MEM_WAIT entry are cleared before the next.
        foreach (vecs[i]) begin
            @(negedge clk);
            drive_vec(vecs[i]);
            #1;
            chk({vecs[i].name, "_stall"}, stalls(), {4'b0, vecs[i].exp_stall});
            chk({vecs[i].name, "_flush"}, flushes(), {5'b0, vecs[i].exp_flush});
            chk({vecs[i].name, "_fa"}, {6'b0, hif.fwd_a_E}, {6'b0, vecs[i].exp_fa});
            chk({vecs[i].name, "_fb"}, {6'b0, hif.fwd_b_E}, {6'b0, vecs[i].exp_fb});
            @(negedge clk);
            drive_idle();
            @(negedge clk);
        end

        // Load-use held for two cycles stalls only once
        @(negedge clk);
        drive_idle();
        hif.dmem_ack = 1'b0;
        hif.mem_rd_E = 1'b1; hif.rd_E = 5'd5; hif.rs1_D = 5'd5;
        #1;
        chk("lu_seq_c1", stalls() | flushes() << 4, 8'h2C);
        @(negedge clk);
        chk("lu_seq_c2", stalls() | flushes() << 4, 8'h00);
        drive_idle();
        hif.dmem_ack = 1'b0;
        @(negedge clk);

        // Memory wait: three stalled cycles, released in the ack cycle
        hif.dmem_req_M = 1'b1;
        #1;
        chk("mw_c1_stall", stalls(), 8'h0F);
        chk("mw_c1_state", {6'b0, hif.ctrl_state}, 8'h00);
        @(negedge clk);
        chk("mw_c2_stall", stalls(), 8'h0F);
        chk("mw_c2_state", {6'b0, hif.ctrl_state}, 8'h01);
        @(negedge clk);
        chk("mw_c3_stall", stalls(), 8'h0F);
        chk("mw_c3_flushw", flushes(), 8'h01);
        @(negedge clk);
        hif.dmem_ack = 1'b1;
        #1;
        chk("mw_ack_stall", stalls(), 8'h00);
        chk("mw_ack_state", {6'b0, hif.ctrl_state}, 8'h01);
        @(negedge clk);
        chk("mw_back_run", {6'b0, hif.ctrl_state}, 8'h00);
        hif.dmem_req_M = 1'b0;
        hif.dmem_ack   = 1'b0;

        // Timeout: RUN edge, then MEM_WAIT with counter 0..4, ERR on the 6th edge
        @(negedge clk);
        hif.dmem_req_M = 1'b1;
        edges = 0;
        while (hif.ctrl_state != 2'b10 && edges < 20) begin
            @(negedge clk);
            edges++;
            if (edges == 5) chk("to_not_yet", {7'b0, hif.mem_timeout}, 8'h00);
        end
        chk("to_edges", edges[7:0], 8'd6);
        chk("to_flag", {7'b0, hif.mem_timeout}, 8'h01);
        hif.dmem_req_M = 1'b0;
        hif.pc_src_E = 1'b1;
        hif.mem_rd_E = 1'b1; hif.rd_E = 5'd5; hif.rs1_D = 5'd5;
        #1;
        chk("err_stall", stalls(), 8'h0F);
        chk("err_flush", flushes(), 8'h01);
        hif.dmem_ack = 1'b1;
        repeat (3) @(negedge clk);
        chk("err_sticky", {6'b0, hif.ctrl_state}, 8'h02);
        chk("err_flag_sticky", {7'b0, hif.mem_timeout}, 8'h01);
        drive_idle();
        #2;
        rst_n = 1'b0;
        #1;
        chk("err_rst_state", {6'b0, hif.ctrl_state}, 8'h00);
        chk("err_rst_flag", {7'b0, hif.mem_timeout}, 8'h00);
        chk("err_rst_stall", stalls(), 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Async reset mid-MEM_WAIT, between edges
        @(negedge clk);
        hif.dmem_ack = 1'b0;
        hif.dmem_req_M = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("ar_in_mw", {6'b0, hif.ctrl_state}, 8'h01);
        #2;
        hif.dmem_req_M = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("ar_state", {6'b0, hif.ctrl_state}, 8'h00);
        chk("ar_stall", stalls() | flushes() << 4, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
        hif.dmem_req_M = 1'b1;
        @(negedge clk);
        chk("ar_first_edge", {6'b0, hif.ctrl_state}, 8'h01);
        hif.dmem_ack = 1'b1;
        @(negedge clk);
        drive_idle();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
